// File: rtl/bus_wait_gen.sv
// Bus wait-state generator: stretches memory and I/O cycles via open-drain nws.
// Define BUS_WAIT_GEN_TIMEOUT_EN to build the nws watchdog and sticky buserr.
module bus_wait_gen #(
    parameter logic [3:0]  MEM_WS    = 4'd1,
    parameter logic [3:0]  IO_WS     = 4'd3,
    parameter logic [3:0]  SLOW_WS   = 4'd7,
    parameter logic [23:0] SLOW_BASE = 24'hF00000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk4,
    input  logic        reset,
    input  logic        nmem,
    input  logic        nio,
    input  logic        nr,
    input  logic        nw,
    input  logic [23:0] ab,
    input  logic        nws_in,
    output tri          nws,
    output logic        busy,
    output logic [3:0]  wscount,
    output logic        buserr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] count_nx;
    logic       drive;
    logic       drive_nx;
    logic       active;
    logic [3:0] n_sel;
    logic       wd_hit;

    assign active = (~nmem | ~nio) & (~nr | ~nw);
    assign busy   = (state != IDLE);

    // Released line floats; the board pull-up supplies the high level.
    assign nws = drive ? 1'b0 : 1'bz;

    // I/O wins when both space strobes are low.
    always_comb begin
        n_sel = MEM_WS;
        if (!nio)
            n_sel = IO_WS;
        else if (ab >= SLOW_BASE)
            n_sel = SLOW_WS;
    end

    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wscount <= 4'd0;
            drive   <= 1'b0;
        end else begin
            state   <= state_nx;
            wscount <= count_nx;
            drive   <= drive_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = wscount;
        drive_nx = drive;
        case (state)
            IDLE: begin
                if (active) begin
                    count_nx = n_sel;
                    if (n_sel == 4'd0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = WAIT;
                        drive_nx = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!active) begin
                    state_nx = IDLE;
                    count_nx = 4'd0;
                    drive_nx = 1'b0;
                end else if (wscount <= 4'd1) begin
                    state_nx = DONE;
                    count_nx = 4'd0;
                    drive_nx = 1'b0;
                end else begin
                    count_nx = wscount - 4'd1;
                end
            end
            DONE: begin
                if (!active)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                count_nx = 4'd0;
                drive_nx = 1'b0;
            end
        endcase
        // A stuck line overrides whatever the cycle was doing.
        if (wd_hit) begin
            state_nx = DONE;
            count_nx = 4'd0;
            drive_nx = 1'b0;
        end
    end

`ifdef BUS_WAIT_GEN_TIMEOUT_EN
    logic [7:0] wd_count;

    assign wd_hit = !nws_in && (wd_count < TIMEOUT)
                    && ((wd_count + 8'd1) == TIMEOUT);

    // Count saturates at TIMEOUT so a long stall cannot wrap and re-fire.
    always_ff @(posedge clk4 or posedge reset) begin
        if (reset) begin
            wd_count <= 8'd0;
            buserr   <= 1'b0;
        end else begin
            if (nws_in)
                wd_count <= 8'd0;
            else if (wd_count < TIMEOUT)
                wd_count <= wd_count + 8'd1;
            if (wd_hit)
                buserr <= 1'b1;
        end
    end
`else
    logic [8:0] unused_wd;

    assign unused_wd = {nws_in, TIMEOUT};
    assign wd_hit    = 1'b0;
    assign buserr    = 1'b0;
`endif

endmodule

// File: doc/bus_wait_gen.md
BUS_WAIT_GEN -- requirements
Module: bus_wait_gen

Interface
REQ-001 Parameter MEM_WS, default 4'd1: wait states for memory cycles below SLOW_BASE.
REQ-002 Parameter IO_WS, default 4'd3: wait states for I/O cycles.
REQ-003 Parameter SLOW_WS, default 4'd7: wait states for memory cycles at or above SLOW_BASE.
REQ-004 Parameter SLOW_BASE, default 24'hF00000: lowest address of the slow memory window.
REQ-005 Parameter TIMEOUT, default 8'd255: bus watchdog limit in clk4 cycles.
REQ-006 Port clk4, input, 1: sole clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Ports nmem, nio, input, 1 each: active-low memory and I/O space strobes.
REQ-009 Ports nr, nw, input, 1 each: active-low read and write strobes.
REQ-010 Port ab, input, 24: address bus.
REQ-011 Port nws_in, input, 1: sensed level of the shared open-drain nws line.
REQ-012 Port nws, output, 1: open-drain wait request; drives 0 when asserting, otherwise Z.
REQ-013 Port busy, output, 1: high in any state other than IDLE.
REQ-014 Port wscount, output, 4: wait states still to be inserted.
REQ-015 Port buserr, output, 1: sticky bus-timeout flag.

Function
REQ-016 The block SHALL implement states IDLE, WAIT and DONE.
REQ-017 Cycle start SHALL be (nmem==0 or nio==0) and (nr==0 or nw==0), sampled in IDLE.
REQ-018 At start, n SHALL be IO_WS if nio==0, otherwise SLOW_WS if ab>=SLOW_BASE, otherwise MEM_WS.
REQ-019 nio==0 SHALL take precedence when nmem and nio are low together.
REQ-020 ab SHALL be sampled only at start; later address changes SHALL be ignored.
REQ-021 If n==0, IDLE SHALL go to DONE with nws never asserted.
REQ-022 If n>0, IDLE SHALL go to WAIT with nws registered low from the start edge.
REQ-023 nws SHALL stay low for exactly n clk4 periods.
REQ-024 wscount SHALL load n at start and decrement once per clock in WAIT.
REQ-025 WAIT SHALL go to DONE and release nws (Z) on the edge where wscount reaches 0.
REQ-026 DONE SHALL go to IDLE once nmem and nio are both high, or nr and nw are both high.
REQ-027 Back-to-back cycles SHALL require at least one IDLE clock between them.
REQ-028 If strobes deassert in WAIT (abort), the block SHALL release nws, clear wscount and enter IDLE on the next edge.

Reset
REQ-029 While reset is high, state SHALL be IDLE, nws Z, busy 0, wscount 0, buserr 0, and the watchdog count 0.
REQ-030 Reset asserted mid-cycle SHALL release nws immediately, without waiting for a clock.

Configuration
REQ-031 Macro BUS_WAIT_GEN_TIMEOUT_EN SHALL enable the bus watchdog.
REQ-032 With the macro, the watchdog SHALL count consecutive clocks where nws_in==0 and clear whenever nws_in==1.
REQ-033 With the macro, when the count reaches TIMEOUT, buserr SHALL set, nws SHALL release and the state SHALL go to DONE.
REQ-034 buserr SHALL stay set until reset.
REQ-035 The watchdog count SHALL saturate and never wrap.
REQ-036 Without the macro, buserr SHALL be constant 0 and no watchdog logic SHALL be built.

Verification
REQ-037 Memory read, ab=24'h001000, defaults -> nws low exactly 1 clock; busy returns low after nr rises.
REQ-038 I/O write with nmem and nio both low -> IO_WS=3 selected; nws low 3 clocks; wscount shows 3,2,1,0.
REQ-039 Memory read at ab=24'hF00000 -> 7 wait clocks; ab changed mid-cycle to 24'h000000 -> still 7.
REQ-040 Abort: nr raised after 2 of 7 wait clocks -> nws Z on the next edge, state IDLE, wscount 0.
REQ-041 Reset pulsed while nws is low -> nws Z with no clock edge; all outputs at reset values.
REQ-042 With BUS_WAIT_GEN_TIMEOUT_EN, TIMEOUT=8'd16, nws_in held low externally -> buserr=1 after 16 clocks and stays 1 until reset.
